// File: rtl/sega_pad_scanner.sv
// Two-port Sega pad scanner: drives the shared select line and decodes SMS, 3- and 6-button pads.
// Build option: define SEGA_SIX_BUTTON_EN to run the full 8-step sequence with 6-button detection.
module sega_pad_scanner #(
  parameter int STEP_DIV   = 128,
  parameter int IDLE_STEPS = 160
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        en_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        sel_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  // state | meaning
  // IDLE  | sel high for IDLE_STEPS steps so the pad's internal counter times out
  // SCAN  | r_step 0..LAST_STEP, sel high on even steps, pins sampled at each step end
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [11:0] PRESC_LAST = 12'(STEP_DIV - 1);
  localparam logic [9:0]  IDLE_LAST  = 10'(IDLE_STEPS - 1);
`ifdef SEGA_SIX_BUTTON_EN
  localparam logic [2:0]  LAST_STEP  = 3'd7;
  localparam logic [11:0] JOY_MASK   = 12'hFFF;
  localparam logic        SIX_EN     = 1'b1;
`else
  localparam logic [2:0]  LAST_STEP  = 3'd1;
  localparam logic [11:0] JOY_MASK   = 12'h0FF;
  localparam logic        SIX_EN     = 1'b0;
`endif

  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;

  logic [1:0][5:0]  r_meta;
  logic [1:0][5:0]  r_pins;
  logic [11:0]      r_presc;
  logic [9:0]       r_idle_cnt;
  logic [0:0]       r_state;
  logic [2:0]       r_step;
  logic             r_sel;
  logic             r_done;
  logic [1:0][11:0] r_shadow;
  logic [1:0]       r_six_sh;
  logic [1:0][11:0] r_joy;
  logic [1:0]       r_six;
  logic             r_frame;

  logic             w_step_end;
  logic             w_sample;
  logic [0:0]       w_state_nxt;
  logic [2:0]       w_step_nxt;
  logic [9:0]       w_idle_nxt;
  logic             w_sel_nxt;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_meta <= '0;
      r_pins <= '0;
    end else begin
      r_meta <= {joy2_i, joy1_i};
      r_pins <= r_meta;
    end
  end

  assign w_step_end = (r_presc == PRESC_LAST);
  assign w_sample   = w_step_end && (r_state == ST_SCAN);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_presc <= '0;
    end else if (w_step_end) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 12'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_idle_nxt  = r_idle_cnt;
    if (w_step_end) begin
      case (r_state)
        ST_IDLE: begin
          if (r_idle_cnt == IDLE_LAST) begin
            w_idle_nxt = '0;
            if (en_i) begin
              w_state_nxt = ST_SCAN;
              w_step_nxt  = '0;
            end
          end else begin
            w_idle_nxt = r_idle_cnt + 10'd1;
          end
        end
        default: begin
          if (r_step == LAST_STEP) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = '0;
          end else begin
            w_step_nxt = r_step + 3'd1;
          end
        end
      endcase
    end
    w_sel_nxt = (w_state_nxt == ST_IDLE) || !w_step_nxt[0];
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_state    <= ST_IDLE;
      r_step     <= '0;
      r_idle_cnt <= '0;
      r_sel      <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_sel      <= w_sel_nxt;
      r_done     <= w_sample && (r_step == LAST_STEP);
    end
  end

  // Every shadow bit is rewritten each frame, so a removed pad reads released next frame.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_shadow <= '0;
      r_six_sh <= '0;
    end else if (w_sample) begin
      for (int p = 0; p < 2; p++) begin
        case (r_step)
          3'd0: r_shadow[p][5:0] <= ~r_pins[p];
          3'd1: r_shadow[p][7:6] <= (r_pins[p][PIN_LEFT] || r_pins[p][PIN_RIGHT]) ?
                                    2'b00 : ~r_pins[p][5:4];
`ifdef SEGA_SIX_BUTTON_EN
          3'd5: r_six_sh[p] <= (r_pins[p][3:0] == 4'b0000);
          3'd6: r_shadow[p][11:8] <= r_six_sh[p] ? ~r_pins[p][3:0] : 4'b0000;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_joy   <= '0;
      r_six   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= r_done;
      if (r_done) begin
        r_joy[0] <= r_shadow[0] & JOY_MASK;
        r_joy[1] <= r_shadow[1] & JOY_MASK;
        r_six    <= r_six_sh & {2{SIX_EN}};
      end
    end
  end

  assign sel_o   = r_sel;
  assign joy1_o  = r_joy[0];
  assign joy2_o  = r_joy[1];
  assign six1_o  = r_six[0];
  assign six2_o  = r_six[1];
  assign frame_o = r_frame;

endmodule

// File: tb/tb_sega_pad_scanner.sv
// Bench for sega_pad_scanner: pad models on both ports, time-based output model, directed pad vectors.
// Honours SEGA_SIX_BUTTON_EN the same way as the design.
module tb_sega_pad_scanner;

  localparam int STEP_DIV   = 4;
  localparam int IDLE_STEPS = 2;
`ifdef SEGA_SIX_BUTTON_EN
  localparam int          SCAN_STEPS = 8;
  localparam logic [11:0] TB_MASK    = 12'hFFF;
  localparam logic        TB_SIX     = 1'b1;
  localparam int          EXP_FIRST  = 42;
  localparam int          EXP_PERIOD = 40;
  localparam logic [11:0] EXP_AZ     = 12'h140;
  localparam logic [11:0] EXP_CZ     = 12'h120;
`else
  localparam int          SCAN_STEPS = 2;
  localparam logic [11:0] TB_MASK    = 12'h0FF;
  localparam logic        TB_SIX     = 1'b0;
  localparam int          EXP_FIRST  = 18;
  localparam int          EXP_PERIOD = 16;
  localparam logic [11:0] EXP_AZ     = 12'h040;
  localparam logic [11:0] EXP_CZ     = 12'h020;
`endif

  logic        clk_i = 1'b0;
  logic        res_n_i;
  logic        en_i;
  logic [5:0]  joy1_i;
  logic [5:0]  joy2_i;
  logic        sel_o;
  logic [11:0] joy1_o;
  logic [11:0] joy2_o;
  logic        six1_o;
  logic        six2_o;
  logic        frame_o;

  // pad type: 0 none, 1 Master System, 2 three-button, 3 six-button
  int          pad1_ty = 0;
  int          pad2_ty = 0;
  logic [11:0] pad1_m  = '0;
  logic [11:0] pad2_m  = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int t = 0;
  int check_at = 0;
  int scan_from = -1000000;
  int frames_seen = 0;
  int last_frame_cyc = 0;

  logic [11:0] exp_j1, exp_j2;
  logic        exp_s1, exp_s2, exp_fr, exp_sel;

  sega_pad_scanner #(.STEP_DIV(STEP_DIV), .IDLE_STEPS(IDLE_STEPS)) dut (
    .clk_i(clk_i), .res_n_i(res_n_i), .en_i(en_i), .joy1_i(joy1_i), .joy2_i(joy2_i),
    .sel_o(sel_o), .joy1_o(joy1_o), .joy2_o(joy2_o), .six1_o(six1_o), .six2_o(six2_o),
    .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [11:0] pad_word(input int ty, input logic [11:0] m);
    case (ty)
      1:       return m & 12'h03F;
      2:       return m & 12'h0FF;
      3:       return m & TB_MASK;
      default: return 12'h000;
    endcase
  endfunction

  // What a pad drives (as pressed=1) given sel and the number of sel-low phases seen.
  function automatic logic [5:0] pad_pressed(input int ty, input logic [11:0] m,
                                             input logic sel, input int lc);
    logic [5:0] pr;
    pr = 6'b0;
    case (ty)
      1: pr = m[5:0];
      2: pr = sel ? m[5:0] : {m[7:6], 2'b11, m[1:0]};
      3: begin
        if (sel)          pr = (lc == 3) ? {m[5:4], m[11:8]} : m[5:0];
        else if (lc == 3) pr = {m[7:6], 4'b1111};
        else if (lc == 4) pr = {m[7:6], 4'b0000};
        else              pr = {m[7:6], 2'b11, m[1:0]};
      end
      default: pr = 6'b0;
    endcase
    return pr;
  endfunction

  initial begin : pad_model
    int lowcnt;
    int hicnt;
    logic prev;
    lowcnt = 0;
    hicnt  = 0;
    prev   = 1'b1;
    forever begin
      @(negedge clk_i);
      if (sel_o) begin
        hicnt++;
        if (hicnt >= 8) lowcnt = 0;
      end else begin
        hicnt = 0;
        if (prev) lowcnt++;
      end
      prev   = sel_o;
      joy1_i = ~pad_pressed(pad1_ty, pad1_m, sel_o, lowcnt);
      joy2_i = ~pad_pressed(pad2_ty, pad2_m, sel_o, lowcnt);
    end
  end

  // t counts rising edges since reset release; the scan schedule is derived from it.
  initial begin : model_cmp
    int rel;
    forever begin
      @(negedge clk_i);
      if (!res_n_i) begin
        t = 0;
        check_at = IDLE_STEPS * STEP_DIV;
        scan_from = -1000000;
        exp_j1 = '0; exp_j2 = '0; exp_s1 = 1'b0; exp_s2 = 1'b0;
        exp_fr = 1'b0; exp_sel = 1'b1;
      end else begin
        t++;
        if (t == check_at) begin
          if (en_i) begin
            scan_from = t;
            check_at  = t + (SCAN_STEPS + IDLE_STEPS) * STEP_DIV;
          end else begin
            check_at  = t + IDLE_STEPS * STEP_DIV;
          end
        end
        exp_fr = (t == scan_from + SCAN_STEPS * STEP_DIV + 1);
        if (exp_fr) begin
          exp_j1 = pad_word(pad1_ty, pad1_m);
          exp_j2 = pad_word(pad2_ty, pad2_m);
          exp_s1 = TB_SIX && (pad1_ty == 3);
          exp_s2 = TB_SIX && (pad2_ty == 3);
        end
        rel = t - scan_from;
        exp_sel = !(rel >= 0 && rel < SCAN_STEPS * STEP_DIV && ((rel / STEP_DIV) % 2) == 1);
      end
      check("sel_o",   12'(sel_o),   12'(exp_sel));
      check("frame_o", 12'(frame_o), 12'(exp_fr));
      check("joy1_o",  joy1_o,       exp_j1);
      check("joy2_o",  joy2_o,       exp_j2);
      check("six1_o",  12'(six1_o),  12'(exp_s1));
      check("six2_o",  12'(six2_o),  12'(exp_s2));
      if (frame_o) begin
        frames_seen++;
        last_frame_cyc = t + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_frame(output int cyc);
    int n0;
    bit got;
    n0  = frames_seen;
    got = 1'b0;
    cyc = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (frames_seen != n0) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_frame: no frame_o within 300 cycles");
    end else begin
      cyc = last_frame_cyc;
    end
  endtask

  task automatic wait_sel_low();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (!sel_o) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_sel_low: sel_o never low within 300 cycles");
    end
  endtask

  localparam int NV = 7;
  int          v_ty1 [NV] = '{3, 3, 2, 3, 0, 1, 3};
  logic [11:0] v_m1  [NV] = '{12'h140, 12'h120, 12'h0C5, 12'hA5A, 12'h0F0, 12'h016, 12'h5A5};
  int          v_ty2 [NV] = '{2, 1, 3, 1, 3, 2, 0};
  logic [11:0] v_m2  [NV] = '{12'h020, 12'h030, 12'h5A5, 12'h009, 12'hFFF, 12'h0CA, 12'h000};

  initial begin : stim
    int c1;
    int c2;
    int n0;
    res_n_i = 1'b0;
    en_i    = 1'b1;
    joy1_i  = 6'h3F;
    joy2_i  = 6'h3F;
    repeat (3) tick();
    check("reset_sel",   12'(sel_o),   12'h001);
    check("reset_joy1",  joy1_o,       12'h000);
    check("reset_frame", 12'(frame_o), 12'h000);

    res_n_i = 1'b1;
    wait_frame(c1);
    check("first_frame_cycle", 12'(c1), 12'(EXP_FIRST));
    check("idle_pad_joy1", joy1_o, 12'h000);
    wait_frame(c2);
    check("frame_period", 12'(c2 - c1), 12'(EXP_PERIOD));

    for (int v = 0; v < NV; v++) begin
      pad1_ty = v_ty1[v]; pad1_m = v_m1[v];
      pad2_ty = v_ty2[v]; pad2_m = v_m2[v];
      wait_frame(c1);
      if (v == 0) begin
        check("six_AZ_joy1",   joy1_o,      EXP_AZ);
        check("six_AZ_six1",   12'(six1_o), 12'(TB_SIX));
        check("three_C_joy2",  joy2_o,      12'h020);
        check("three_C_six2",  12'(six2_o), 12'h000);
      end else if (v == 1) begin
        check("six_CZ_joy1",   joy1_o,      EXP_CZ);
        check("sms_12_joy2",   joy2_o,      12'h030);
      end
    end

    wait_sel_low();
`ifdef SEGA_SIX_BUTTON_EN
    repeat (12) tick();
`endif
    res_n_i = 1'b0;
    #1;
    check("abort_sel",   12'(sel_o),   12'h001);
    check("abort_joy1",  joy1_o,       12'h000);
    check("abort_joy2",  joy2_o,       12'h000);
    check("abort_six1",  12'(six1_o),  12'h000);
    check("abort_frame", 12'(frame_o), 12'h000);
    repeat (2) tick();
    res_n_i = 1'b1;
    wait_frame(c1);
    check("first_frame_after_abort", 12'(c1), 12'(EXP_FIRST));

    wait_sel_low();
`ifdef SEGA_SIX_BUTTON_EN
    repeat (8) tick();
`endif
    en_i = 1'b0;
    wait_frame(c1);
    n0 = frames_seen;
    repeat (3 * EXP_PERIOD) tick();
    check("no_frame_after_en_drop", 12'(frames_seen - n0), 12'h000);
    check("sel_high_after_en_drop", 12'(sel_o), 12'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
